command_debouncer: RTL and testbench



---
 rtl/command_debouncer_pkg.sv | 26 ++
 rtl/command_debouncer_if.sv | 33 +++
 rtl/command_debouncer_channel.sv | 39 +++
 rtl/command_debouncer.sv | 59 +++++
 tb/tb_command_debouncer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/command_debouncer_pkg.sv
// rtl/command_debouncer_pkg.sv - shared types, debounce count and counter width for the command debouncer
package debouncer_pkg;

    typedef enum logic [1:0] {
        PLAY        = 2'd0,
        RECORD      = 2'd1,
        PLAY_CLIP   = 2'd2,
        RECORD_CLIP = 2'd3
    } channel_e;

    localparam int unsigned NUM_CHANNELS = 4;

    function automatic int unsigned debounce_count(input int unsigned system_frequency,
                                                   input int unsigned debounce_us);
        return system_frequency * debounce_us;
    endfunction

    // Counter only has to reach N-1, so $clog2(N) bits suffice; floor of 1 bit.
    function automatic int unsigned counter_width(input int unsigned count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

    localparam int unsigned DEFAULT_COUNT = debounce_count(100, 10000);
    localparam int unsigned CNT_W         = counter_width(DEFAULT_COUNT);

endpackage

// File: rtl/command_debouncer_if.sv
// rtl/command_debouncer_if.sv - front-panel inputs and conditioned outputs of the command debouncer
interface command_debouncer_if;
    logic play_command_i;
    logic record_command_i;
    logic play_clip_select_i;
    logic record_clip_select_i;
    logic play_pulse_o;
    logic record_pulse_o;
    logic play_clip_o;
    logic record_clip_o;

    modport master (
        output play_command_i,
        output record_command_i,
        output play_clip_select_i,
        output record_clip_select_i,
        input  play_pulse_o,
        input  record_pulse_o,
        input  play_clip_o,
        input  record_clip_o
    );

    modport slave (
        input  play_command_i,
        input  record_command_i,
        input  play_clip_select_i,
        input  record_clip_select_i,
        output play_pulse_o,
        output record_pulse_o,
        output play_clip_o,
        output record_clip_o
    );
endinterface

// File: rtl/command_debouncer_channel.sv
// rtl/command_debouncer_channel.sv - one debounced input: stable level, stability counter, rise flag
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned COUNT = DEFAULT_COUNT,
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lvl  <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (raw == lvl) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Accept the new level; flag only the 0->1 transition.
                lvl  <= raw;
                cnt  <= '0;
                rise <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_debouncer.sv
// rtl/command_debouncer.sv - debounces four front-panel inputs; play/record become single-cycle pulses
module command_debouncer
    import debouncer_pkg::*;
#(
    parameter int unsigned SYSTEM_FREQUENCY = 100,
    parameter int unsigned DEBOUNCE_US      = 10000
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    command_debouncer_if.slave   bus
);

    localparam int unsigned N     = debounce_count(SYSTEM_FREQUENCY, DEBOUNCE_US);
    localparam int unsigned WIDTH = counter_width(N);

    logic [NUM_CHANNELS-1:0] raw;
    logic [NUM_CHANNELS-1:0] lvl;
    logic [NUM_CHANNELS-1:0] rise;
    logic [1:0]              clip_rise_unused;
    logic                    play_pulse;
    logic                    record_pulse;

    assign raw[PLAY]        = bus.play_command_i;
    assign raw[RECORD]      = bus.record_command_i;
    assign raw[PLAY_CLIP]   = bus.play_clip_select_i;
    assign raw[RECORD_CLIP] = bus.record_clip_select_i;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        debounce_channel #(
            .COUNT (N),
            .WIDTH (WIDTH)
        ) u_channel (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .raw     (raw[i]),
            .lvl     (lvl[i]),
            .rise    (rise[i])
        );
    end

    assign clip_rise_unused = {rise[RECORD_CLIP], rise[PLAY_CLIP]};

    // Record wins a same-cycle tie; the play press is dropped, not held over.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            play_pulse   <= 1'b0;
            record_pulse <= 1'b0;
        end else begin
            play_pulse   <= rise[PLAY] & ~rise[RECORD];
            record_pulse <= rise[RECORD];
        end
    end

    assign bus.play_pulse_o   = play_pulse;
    assign bus.record_pulse_o = record_pulse;
    assign bus.play_clip_o    = lvl[PLAY_CLIP];
    assign bus.record_clip_o  = lvl[RECORD_CLIP];

endmodule

// File: tb/tb_command_debouncer.sv
// tb/tb_command_debouncer.sv - directed self-checking bench for command_debouncer with N = 100
module tb_command_debouncer;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    command_debouncer_if ifc ();

    command_debouncer #(
        .SYSTEM_FREQUENCY (100),
        .DEBOUNCE_US      (1)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (ifc.slave)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    int step_no;
    int play_n;
    int play_at;
    int rec_n;
    int rec_at;

    task automatic clear_mon();
        step_no = 0;
        play_n  = 0;
        play_at = 0;
        rec_n   = 0;
        rec_at  = 0;
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
        step_no++;
        if (ifc.play_pulse_o === 1'b1) begin
            play_n++;
            if (play_at == 0) play_at = step_no;
        end
        if (ifc.record_pulse_o === 1'b1) begin
            rec_n++;
            if (rec_at == 0) rec_at = step_no;
        end
    endtask

    task automatic set_inputs(input logic [3:0] v);
        ifc.play_command_i       = v[0];
        ifc.record_command_i     = v[1];
        ifc.play_clip_select_i   = v[2];
        ifc.record_clip_select_i = v[3];
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        reset_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_inputs((i % 2 == 0) ? 4'b1111 : 4'b0000);
            tick();
            outs = {ifc.record_clip_o, ifc.play_clip_o, ifc.record_pulse_o, ifc.play_pulse_o};
            checks++;
            if (outs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: outputs=%b expected=0000", i, outs);
            end
        end
        set_inputs(4'b0000);
        reset_i = 1'b0;
        tick();
        outs = {ifc.record_clip_o, ifc.play_clip_o, ifc.record_pulse_o, ifc.play_pulse_o};
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: outputs=%b expected=0000", outs);
        end
    endtask

    task automatic test_clean_press();
        clear_mon();
        ifc.play_command_i = 1'b1;
        repeat (150) tick();
        ifc.play_command_i = 1'b0;
        repeat (150) tick();
        checks++;
        if (play_n !== 1) begin
            errors++;
            $display("FAIL clean_play_count: got %0d expected 1", play_n);
        end
        checks++;
        if (play_at !== 101) begin
            errors++;
            $display("FAIL clean_play_latency: got %0d expected 101", play_at);
        end
        checks++;
        if (rec_n !== 0) begin
            errors++;
            $display("FAIL clean_record_quiet: got %0d expected 0", rec_n);
        end
    endtask

    task automatic test_bounce();
        clear_mon();
        for (int k = 0; k < 10; k++) begin
            ifc.record_command_i = (k % 2 == 0);
            repeat (30) tick();
        end
        ifc.record_command_i = 1'b0;
        repeat (50) tick();
        checks++;
        if (rec_n !== 0) begin
            errors++;
            $display("FAIL bounce_record: got %0d pulses expected 0", rec_n);
        end
        checks++;
        if (play_n !== 0) begin
            errors++;
            $display("FAIL bounce_play: got %0d pulses expected 0", play_n);
        end
        // A clean press afterwards must see a counter that started from zero.
        clear_mon();
        ifc.record_command_i = 1'b1;
        repeat (120) tick();
        ifc.record_command_i = 1'b0;
        repeat (150) tick();
        checks++;
        if (rec_at !== 101) begin
            errors++;
            $display("FAIL bounce_recovery_latency: got %0d expected 101", rec_at);
        end
        checks++;
        if (rec_n !== 1) begin
            errors++;
            $display("FAIL bounce_recovery_count: got %0d expected 1", rec_n);
        end
    endtask

    task automatic test_simultaneous();
        clear_mon();
        ifc.play_command_i   = 1'b1;
        ifc.record_command_i = 1'b1;
        repeat (120) tick();
        ifc.play_command_i   = 1'b0;
        ifc.record_command_i = 1'b0;
        repeat (150) tick();
        checks++;
        if (rec_n !== 1) begin
            errors++;
            $display("FAIL simul_record_count: got %0d expected 1", rec_n);
        end
        checks++;
        if (rec_at !== 101) begin
            errors++;
            $display("FAIL simul_record_latency: got %0d expected 101", rec_at);
        end
        checks++;
        if (play_n !== 0) begin
            errors++;
            $display("FAIL simul_play_dropped: got %0d expected 0", play_n);
        end
    endtask

    task automatic test_clip_level();
        int rise_at;
        int fall_at;
        int pclip_seen;
        clear_mon();
        rise_at    = 0;
        pclip_seen = 0;
        ifc.record_clip_select_i = 1'b1;
        repeat (120) begin
            tick();
            if (ifc.record_clip_o === 1'b1 && rise_at == 0) rise_at = step_no;
            if (ifc.play_clip_o !== 1'b0) pclip_seen++;
        end
        checks++;
        if (rise_at !== 100) begin
            errors++;
            $display("FAIL clip_rise: got step %0d expected 100", rise_at);
        end
        ifc.record_clip_select_i = 1'b0;
        step_no = 0;
        fall_at = 0;
        repeat (150) begin
            tick();
            if (ifc.record_clip_o === 1'b0 && fall_at == 0) fall_at = step_no;
            if (ifc.play_clip_o !== 1'b0) pclip_seen++;
        end
        checks++;
        if (fall_at !== 100) begin
            errors++;
            $display("FAIL clip_fall: got step %0d expected 100", fall_at);
        end
        checks++;
        if ((play_n + rec_n) !== 0) begin
            errors++;
            $display("FAIL clip_no_pulse: got %0d pulses expected 0", play_n + rec_n);
        end
        checks++;
        if (pclip_seen !== 0) begin
            errors++;
            $display("FAIL clip_play_quiet: got %0d high cycles expected 0", pclip_seen);
        end
    endtask

    task automatic test_reset_mid_count();
        int release_step;
        clear_mon();
        ifc.play_command_i = 1'b1;
        repeat (50) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        release_step = step_no;
        repeat (200) tick();
        ifc.play_command_i = 1'b0;
        repeat (150) tick();
        checks++;
        if (play_n !== 1) begin
            errors++;
            $display("FAIL midreset_count: got %0d expected 1", play_n);
        end
        checks++;
        if (play_at !== release_step + 101) begin
            errors++;
            $display("FAIL midreset_latency: got %0d expected %0d", play_at, release_step + 101);
        end
    endtask

    initial begin
        set_inputs(4'b0000);
        reset_i = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_clip_level();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
